// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux channel arbiter/multiplexer.
// Holds the arbitration mode encoding and the pointer wrap helper.
package arb_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  // Next round-robin start position: one past the granted index, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// searching upward and wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  int            pos_s;
  logic [SW-1:0] idx_s;

  // Scan from farthest to nearest offset so the nearest valid request wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos_s   = 32'sd0;
    idx_s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos_s   = int'(ptr) + i;
      pos_s   = (pos_s >= N) ? (pos_s - N) : pos_s;
      idx_s   = SW'(pos_s);
      gnt_vld = req[idx_s] ? 1'b1  : gnt_vld;
      gnt_idx = req[idx_s] ? idx_s : gnt_idx;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating multiplexer with a single registered output stage.
// Round-robin or fixed-select grant; one word per cycle when downstream is ready.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int M  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [M-1:0]  in_data [N-1:0],
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [M-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sel
);

  logic [M-1:0]  out_data_r;
  logic          out_valid_r;
  logic [SW-1:0] out_sel_r;
  logic [SW-1:0] rr_ptr_r;

  logic          load_en_s;
  logic          rr_vld_s;
  logic [SW-1:0] rr_idx_s;
  logic          sel_ok_s;
  logic          fix_vld_s;
  logic          gnt_vld_s;
  logic [SW-1:0] gnt_idx_s;
  logic          xfer_s;
  mode_e         mode_s;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (rr_ptr_r),
    .gnt_vld (rr_vld_s),
    .gnt_idx (rr_idx_s)
  );

  assign mode_s    = mode_e'(mode);
  assign load_en_s = !out_valid_r || out_ready;
  // Out-of-range select (non-power-of-two N) never grants.
  assign sel_ok_s  = (int'(sel) < N);
  assign fix_vld_s = sel_ok_s && in_valid[sel];

  // Grant selection between round-robin arbiter and fixed select.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    case (mode_s)
      MODE_RR: begin
        gnt_vld_s = rr_vld_s;
        gnt_idx_s = rr_idx_s;
      end
      MODE_FIXED: begin
        gnt_vld_s = fix_vld_s;
        gnt_idx_s = sel;
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
      end
    endcase
  end

  assign xfer_s   = rst_n && load_en_s && gnt_vld_s;
  assign in_ready = xfer_s ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx_s) : {N{1'b0}};

  // Output register and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_sel_r   <= '0;
      rr_ptr_r    <= '0;
    end else if (xfer_s) begin
      out_data_r  <= in_data[gnt_idx_s];
      out_valid_r <= 1'b1;
      out_sel_r   <= gnt_idx_s;
      rr_ptr_r    <= SW'(wrap_inc(int'(gnt_idx_s), N));
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_arb_mux.sv
// Directed table-driven bench for arb_mux (N=4, M=8), plus an
// asynchronous reset sequence in the middle of a stream.
module tb_arb_mux;

  localparam int N  = 4;
  localparam int M  = 8;
  localparam int SW = 2;

  logic          clk;
  logic          rst_n;
  logic [M-1:0]  in_data [N-1:0];
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [M-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sel;

  int checks;
  int errors;

  arb_mux #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   vld;
    logic         ordy;
    logic [3:0]   exp_rdy;
    logic         exp_ov;
    logic [1:0]   exp_os;
    logic [7:0]   exp_od;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    in_data[0] = 8'd123;
    in_data[1] = 8'd119;
    in_data[2] = 8'd124;
    in_data[3] = 8'd99;
    in_valid  = 4'b0000;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    //            mode  sel   valid    ordy  exp_rdy  ov    os    od
    vecs[0]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd123};
    vecs[1]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd119};
    vecs[2]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd124};
    vecs[3]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'd99};
    vecs[4]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd123};
    vecs[5]  = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd124};
    vecs[6]  = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd124};
    vecs[7]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'd99};
    vecs[8]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd119};
    vecs[9]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'd99};
    vecs[10] = '{1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'd119};
    vecs[11] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd119};
    vecs[12] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd119};
    vecs[13] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd119};
    vecs[14] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'd124};
    vecs[15] = '{1'b1, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd124};
    vecs[16] = '{1'b1, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd2, 8'd124};
    vecs[17] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd123};
    vecs[18] = '{1'b1, 2'd3, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd123};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      mode      = vecs[v].mode;
      sel       = vecs[v].sel;
      in_valid  = vecs[v].vld;
      out_ready = vecs[v].ordy;
      #1;
      check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
      check($sformatf("v%0d_out_sel", v),   32'(out_sel),   32'(vecs[v].exp_os));
      check($sformatf("v%0d_out_data", v),  32'(out_data),  32'(vecs[v].exp_od));
    end

    // Reset mid-stream: asynchronous clear, then search restarts at channel 0
    @(negedge clk);
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data",  32'(out_data),  32'd0);
    check("async_rst_out_sel",   32'(out_sel),   32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk);
    #1;
    check("held_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b1100;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0100);
    @(posedge clk);
    #1;
    check("post_rst_out_sel",  32'(out_sel),  32'd2);
    check("post_rst_out_data", 32'(out_data), 32'd124);
    @(negedge clk);
    in_valid = 4'b1111;
    #1;
    check("post_rst_next_in_ready", 32'(in_ready), 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter N, default 4: number of input channels, N >= 2.
REQ-002 Parameter M, default 8: data width in bits per channel, M >= 1.
REQ-003 Parameter SW, default $clog2(N): width of select/grant indices (derived, not overridden).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  M x N (unpacked array [N-1:0] of [M-1:0])  per-channel data.
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready; at most one bit high in any cycle.
REQ-009 mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed select.
REQ-010 sel  input  SW  channel index used in fixed-select mode.
REQ-011 out_data  output  M  registered output data.
REQ-012 out_valid  output  1  out_data holds an untaken word.
REQ-013 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-014 out_sel  output  SW  index of the channel that supplied out_data.

Function
REQ-015 Transfer on any port occurs when its valid and ready are both high at a rising clk edge.
REQ-016 load_en = !out_valid || out_ready; the output register loads only when load_en is high.
REQ-017 Round-robin mode: grant = first valid channel at or after rr_ptr, searching upward with wrap from N-1 to 0.
REQ-018 Fixed mode: grant = sel if in_valid[sel] is high; otherwise no grant.
REQ-019 sel >= N (non-power-of-two N) in fixed mode: no grant, all in_ready low.
REQ-020 in_ready[g] = load_en && a grant exists && g == grant; all other in_ready bits low.
REQ-021 On an input transfer, out_data <= in_data[grant], out_sel <= grant, out_valid <= 1 at the same edge (latency 1 cycle).
REQ-022 No input transfer but out_valid && out_ready: out_valid <= 0; out_data and out_sel hold.
REQ-023 Output drained and a new word granted in the same cycle: new word loaded, out_valid stays 1 (full throughput, one word per cycle).
REQ-024 out_valid high and out_ready low: out_data, out_sel, out_valid hold unchanged.
REQ-025 rr_ptr <= (grant + 1) mod N after every input transfer in either mode; unchanged otherwise.
REQ-026 mode and sel are sampled combinationally each cycle; a change affects only the next grant, never a word already in the output register.
REQ-027 Grant computation is combinational from in_valid, rr_ptr, mode, sel; no combinational path from in_data to any output.
REQ-028 in_ready never depends combinationally on in_valid of the same channel beyond the grant logic in REQ-017/018.

Reset
REQ-029 While rst_n is low: out_valid = 0, out_data = 0, out_sel = 0, rr_ptr = 0, all in_ready = 0.
REQ-030 Reset asserted mid-transfer discards the output word immediately; no transfer is counted at that edge.
REQ-031 First grant after reset release in round-robin mode starts search at channel 0.

Structure
REQ-032 Shared package arb_mux_pkg holds the mode enum (MODE_RR = 0, MODE_FIXED = 1).
REQ-033 Sub-module rr_arbiter (parameter N): inputs req[N], ptr[SW]; outputs gnt_vld, gnt_idx[SW]; purely combinational.
REQ-034 arb_mux holds the output register, rr_ptr register and mode/sel muxing around rr_arbiter.

Verification
REQ-035 N=4, M=8, mode=0, all valid, out_ready=1, data {99,124,119,123} for ch3..ch0 -> out_sel 0,1,2,3,0 on consecutive cycles, out_data 123,119,124,99,123.
REQ-036 mode=1, sel=2, all valid, out_ready=1 -> every word from ch2 (124), in_ready = 4'b0100 each cycle.
REQ-037 mode=0, only ch1 and ch3 valid, out_ready=1 -> grants alternate 1,3,1,3; ch0/ch2 in_ready stay 0.
REQ-038 Word loaded, out_ready held low 3 cycles -> out_data/out_sel/out_valid stable, all in_ready 0; out_ready high -> next word loads same edge.
REQ-039 mode=1, sel=1, in_valid[1]=0, others valid -> no transfer, out_valid falls to 0 after drain.
REQ-040 rst_n pulled low mid-stream -> out_valid 0, out_data 0 asynchronously; after release first grant is lowest valid channel from 0.
